// File: rtl/spindle_scheduler.sv
// spindle_scheduler: time-multiplexes one spindle core over N_SPINDLE muscles x 3 fibers per tick.
// Optional watchdog abort in WAIT is built when SPINDLE_WATCHDOG_EN is defined.
module spindle_scheduler #(
    parameter int N_SPINDLE = 4,
    parameter int IDX_W     = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             enable,
    output logic             core_start,
    output logic [1:0]       core_fiber,
    output logic [IDX_W-1:0] core_idx,
    input  logic             core_done,
    output logic             st_wr_en,
    output logic             out_wr_en,
    output logic             busy,
    output logic             step_done,
    output logic             overrun,
    output logic             timeout_err,
    input  logic             flag_clr
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, COMMIT, DONE} state_t;
    state_t state, state_n;
    logic [IDX_W-1:0] idx_n;
    logic [1:0] fib_n;
    logic abort, last_fib, last_idx;
    if (N_SPINDLE < 1 || IDX_W < 1 || TIMEOUT < 1) begin : g_param_check
        $error("spindle_scheduler: invalid parameters");
    end
    assign last_fib = core_fiber == 2'd2;
    assign last_idx = core_idx == IDX_W'(N_SPINDLE - 1);
`ifdef SPINDLE_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wd_cnt <= '0;
        else       wd_cnt <= (state != WAIT) ? '0 : wd_cnt + 1'b1;
    end
    assign abort = state == WAIT && !core_done && wd_cnt == CW'(TIMEOUT - 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) timeout_err <= 1'b0;
        else       timeout_err <= abort | (timeout_err & ~flag_clr);
    end
`else
    assign abort = 1'b0;
    assign timeout_err = 1'b0;
`endif
    always_comb begin
        state_n = state;
        idx_n = core_idx;
        fib_n = core_fiber;
        case (state)
            IDLE:    state_n = (tick && enable) ? ISSUE : IDLE;
            ISSUE:   state_n = WAIT;
            WAIT:    state_n = abort ? IDLE : core_done ? COMMIT : WAIT;
            COMMIT: begin
                state_n = (last_fib && last_idx) ? DONE : ISSUE;
                fib_n = last_fib ? 2'd0 : core_fiber + 2'd1;
                idx_n = (last_fib && !last_idx) ? core_idx + 1'b1 : core_idx;
            end
            default: state_n = IDLE;
        endcase
        // index/fiber are zero whenever the FSM rests in IDLE
        if (state_n == IDLE) begin
            idx_n = '0;
            fib_n = '0;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            core_idx   <= '0;
            core_fiber <= '0;
            core_start <= 1'b0;
            st_wr_en   <= 1'b0;
            out_wr_en  <= 1'b0;
            busy       <= 1'b0;
            step_done  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            core_idx   <= idx_n;
            core_fiber <= fib_n;
            core_start <= state_n == ISSUE;
            st_wr_en   <= state_n == COMMIT;
            out_wr_en  <= state_n == COMMIT && fib_n == 2'd2;
            busy       <= state_n != IDLE;
            step_done  <= state_n == DONE;
            overrun    <= (tick && state != IDLE) | (overrun & ~flag_clr);
        end
    end
endmodule
